// File: rtl/ifetch_sequencer_if.sv
// Fetch-side bus bundle: ROM address/data plus the instruction valid/ready hand-off to decode.
// master = sequencer side, slave = ROM/decode side.
interface ifetch_sequencer_if #(
    parameter int ADDR_W = 5
) ();

    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [31:0]       inst_pc;

    modport master (
        output rom_addr,
        output inst_valid,
        output inst,
        output inst_pc,
        input  rom_data,
        input  inst_ready
    );

    modport slave (
        input  rom_addr,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output rom_data,
        output inst_ready
    );

endinterface

// File: rtl/ifetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC, prefetches ROM words into a small FIFO, handles redirects and halt.
// Optional stall counter output enabled by defining IFETCH_STALL_CNT_EN.
module ifetch_sequencer #(
    parameter int          ADDR_W    = 5,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'h0000_007f
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    ifetch_sequencer_if.master  bus,
    output logic                busy,
    output logic                halted,
    output logic [1:0]          dbg_state
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    logic [1:0]       state_q,    state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [31:0]      mem_inst_q [DEPTH];
    logic [31:0]      mem_inst_d [DEPTH];
    logic [31:0]      mem_pc_q   [DEPTH];
    logic [31:0]      mem_pc_d   [DEPTH];
    logic [31:0]      last_inst_q, last_inst_d;
    logic [31:0]      last_pc_q,   last_pc_d;

    logic inst_valid;
    logic pop;
    logic has_space;
    logic flush;
    logic push;

    // Handshake: a word transfers to decode on every rising edge where inst_valid && inst_ready;
    // inst_valid depends only on registered state, never on inst_ready.
    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid && bus.inst_ready;
    assign has_space  = (count_q != DEPTH_C) || pop;
    assign flush      = redirect_valid && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
    assign push       = (state_q == ST_FETCH) && has_space && !flush;

    assign bus.rom_addr   = fetch_pc_q[ADDR_W+1:2];
    assign bus.inst_valid = inst_valid;
    // While empty the outputs keep showing the last word decode saw, not a stale FIFO slot.
    assign bus.inst       = inst_valid ? mem_inst_q[rd_ptr_q] : last_inst_q;
    assign bus.inst_pc    = inst_valid ? mem_pc_q[rd_ptr_q]   : last_pc_q;

    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign halted    = (state_q == ST_HALTED);
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        mem_inst_d  = mem_inst_q;
        mem_pc_d    = mem_pc_q;
        last_inst_d = bus.inst;
        last_pc_d   = bus.inst_pc;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            mem_inst_d[wr_ptr_q] = bus.rom_data;
            mem_pc_d[wr_ptr_q]   = fetch_pc_q;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            fetch_pc_d           = fetch_pc_q + 32'd4;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    fetch_pc_d = RESET_PC;
                end
            end
            ST_FETCH: begin
                if (push && (bus.rom_data == HALT_WORD)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_d == '0) begin
                    state_d = ST_HALTED;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A redirect overrides everything: the handshake this cycle still happened, but the FIFO is dropped.
        if (flush) begin
            state_d    = ST_FETCH;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            last_inst_q <= '0;
            last_pc_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst_q[i] <= '0;
                mem_pc_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            last_inst_q <= last_inst_d;
            last_pc_q   <= last_pc_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst_q[i] <= mem_inst_d[i];
                mem_pc_q[i]   <= mem_pc_d[i];
            end
        end
    end

`ifdef IFETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start) begin
            stall_cnt_d = '0;
        end else if (inst_valid && !bus.inst_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Directed plus randomized bench for ifetch_sequencer; expected instruction stream is derived from the ROM
// image and the fetch rules (sequential PCs, restart on redirect, end after the halt word).
module tb_ifetch_sequencer;

    localparam int          ADDR_W   = 5;
    localparam logic [31:0] HALT     = 32'h0000_007f;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        busy;
    logic        halted;
    logic [1:0]  dbg_state;
`ifdef IFETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    ifetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    logic [31:0] rom [32];
    assign bus.rom_data = rom[bus.rom_addr];

    ifetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus.master),
        .busy           (busy),
        .halted         (halted),
        .dbg_state      (dbg_state)
`ifdef IFETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of {pc, word} still owed to decode, and whether a program is running.
    logic [63:0] exp_q [$];
    bit          active = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void build_stream(input logic [31:0] pc0);
        logic [31:0] p;
        logic [31:0] w;
        exp_q.delete();
        p = {pc0[31:2], 2'b00};
        for (int i = 0; i < 40; i++) begin
            w = rom[p[ADDR_W+1:2]];
            exp_q.push_back({p, w});
            if (w == HALT) break;
            p = p + 32'd4;
        end
    endfunction

    // One clock with scoreboard bookkeeping for whatever the inputs request at the coming edge.
    task automatic step_sb();
        bit          was_active;
        logic [63:0] e;
        was_active = active;
        if (bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", {bus.inst_pc, bus.inst}, 64'hx);
            end else begin
                e = exp_q.pop_front();
                check("pop", {bus.inst_pc, bus.inst}, e);
                if (e[31:0] == HALT) active = 1'b0;
            end
        end
        if (redirect_valid && was_active) begin
            build_stream(redirect_pc);
            active = 1'b1;
        end else if (start && !was_active) begin
            build_stream(RESET_PC);
            active = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_halt(input string tag, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            step_sb();
            n++;
        end
        check({tag, "_halted"}, halted, 1'b1);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  bus.inst_valid, 1'b0);
        check({tag, "_inst"},   bus.inst, 32'h0);
        check({tag, "_pc"},     bus.inst_pc, 32'h0);
        check({tag, "_busy"},   busy, 1'b0);
        check({tag, "_halted"}, halted, 1'b0);
        check({tag, "_addr"},   bus.rom_addr, RESET_PC[ADDR_W+1:2]);
    endtask

    initial begin
        int redirects;
        for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0013 | (i << 20);
        rom[0] = 32'h0050_0293; rom[1] = 32'h0050_0293; rom[2] = 32'h00c0_00ef;
        rom[3] = 32'h0090_0113; rom[4] = 32'h0010_2023; rom[5] = 32'h0010_2623;
        rom[6] = HALT;
        bus.inst_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step_sb();

        // Straight-line program with decode always ready
        bus.inst_ready = 1'b1;
        start = 1'b1;
        step_sb();
        start = 1'b0;
        check("t1_latency_valid0", bus.inst_valid, 1'b0);
        check("t1_busy", busy, 1'b1);
        step_sb();
        for (int i = 0; i < 7; i++) begin
            check("t1_valid", bus.inst_valid, 1'b1);
            check("t1_item", {bus.inst_pc, bus.inst}, {32'(i * 4), rom[i]});
            step_sb();
        end
        check("t1_halted", halted, 1'b1);
        check("t1_busy_low", busy, 1'b0);
        check("t1_valid_low", bus.inst_valid, 1'b0);
        check("t1_hold", {bus.inst_pc, bus.inst}, {32'h18, HALT});
        step_sb();
        check("t1_addr_stop", bus.rom_addr, 5'd7);

        // Redirect while halted must be ignored
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step_sb();
        redirect_valid = 1'b0;
        check("halted_redirect_ignored", {halted, bus.inst_valid, bus.rom_addr}, {1'b1, 1'b0, 5'd7});

        // Back-pressure: FIFO fills to DEPTH, head and ROM address hold
        bus.inst_ready = 1'b0;
        start = 1'b1;
        step_sb();
        start = 1'b0;
        repeat (6) step_sb();
        check("t2_hold_valid", bus.inst_valid, 1'b1);
        check("t2_hold_head", {bus.inst_pc, bus.inst}, {32'h0, rom[0]});
        check("t2_addr_held", bus.rom_addr, 5'd2);
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t2_release", {bus.inst_valid, bus.inst_pc, bus.inst}, {1'b1, 32'(i * 4), rom[i]});
            step_sb();
        end

        // Redirect to a misaligned PC mid-fetch
        redirect_valid = 1'b1;
        redirect_pc = 32'h0E;
        step_sb();
        redirect_valid = 1'b0;
        check("t3_bubble", bus.inst_valid, 1'b0);
        step_sb();
        check("t3_new_head", {bus.inst_valid, bus.inst_pc, bus.inst}, {1'b1, 32'h0C, rom[3]});
        step_sb();
        check("t3_next", {bus.inst_valid, bus.inst_pc, bus.inst}, {1'b1, 32'h10, rom[4]});

        // Redirect near the top of ROM: address wraps
        redirect_valid = 1'b1;
        redirect_pc = 32'h7C;
        step_sb();
        redirect_valid = 1'b0;
        check("t4_bubble", bus.inst_valid, 1'b0);
        check("t4_addr_top", bus.rom_addr, 5'd31);
        step_sb();
        check("t4_head", {bus.inst_valid, bus.inst_pc, bus.inst}, {1'b1, 32'h7C, rom[31]});
        check("t4_addr_wrap", bus.rom_addr, 5'd0);
        step_sb();
        check("t4_wrapped", {bus.inst_valid, bus.inst_pc, bus.inst}, {1'b1, 32'h80, 32'h0050_0293});

        // Asynchronous reset with the FIFO full
        bus.inst_ready = 1'b0;
        repeat (3) step_sb();
        check("t5_full_before_reset", bus.inst_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        exp_q.delete();
        active = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.inst_ready = 1'b1;
        start = 1'b1;
        step_sb();
        start = 1'b0;
        step_sb();
        check("t5_restart", {bus.inst_valid, bus.inst_pc, bus.inst}, {1'b1, 32'h0, rom[0]});
        run_until_halt("t5", 100);

        // Randomized back-pressure, redirects and ignored start pulses against the stream model
        for (int it = 0; it < 25; it++) begin
            redirects = 0;
            start = 1'b1;
            step_sb();
            start = 1'b0;
            for (int c = 0; c < 400 && !halted; c++) begin
                bus.inst_ready = ($urandom_range(0, 3) != 0);
                if (active && redirects < 3 && $urandom_range(0, 15) == 0) begin
                    redirect_valid = 1'b1;
                    redirect_pc = $urandom;
                    redirects++;
                end
                start = active && ($urandom_range(0, 29) == 0);
                step_sb();
                redirect_valid = 1'b0;
                start = 1'b0;
            end
            bus.inst_ready = 1'b1;
            run_until_halt("rand", 200);
        end

`ifdef IFETCH_STALL_CNT_EN
        bus.inst_ready = 1'b0;
        start = 1'b1;
        step_sb();
        start = 1'b0;
        check("stall_cleared", stall_cnt, 16'd0);
        step_sb();
        repeat (5) step_sb();
        check("stall_five", stall_cnt, 16'd5);
        bus.inst_ready = 1'b1;
        run_until_halt("stall_run", 100);
        check("stall_kept", stall_cnt, 16'd5);
        start = 1'b1;
        bus.inst_ready = 1'b0;
        step_sb();
        start = 1'b0;
        check("stall_start_clear", stall_cnt, 16'd0);
        repeat (70000) step_sb();
        check("stall_saturate", stall_cnt, 16'hFFFF);
        bus.inst_ready = 1'b1;
        run_until_halt("stall_end", 100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
